pipe_ctrl: RTL and testbench

Central stall/flush controller for the five-entry in-order pipeline: PC register, if2id, id2ex, ex2mem and mem2wb. It merges per-stage stall requests and the MEM-stage exception into one stall vector and one flush vector, drives the pipeline registers' `stall_i` and `flush_i` inputs, and issues the PC redirect. When an exception arrives while an instruction fetch is still in flight, it holds the redirect until the fetch completes. It also keeps a stall-cycle performance counter.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/sat_counter.sv | 19 +
 rtl/pipe_ctrl.sv | 111 +++++++++++
 tb/tb_pipe_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stage indices,
// controller states and the stall-depth decode helper.
package pipe_pkg;

    localparam int PIPE_PC     = 0;
    localparam int PIPE_IFID   = 1;
    localparam int PIPE_IDEX   = 2;
    localparam int PIPE_EXMEM  = 3;
    localparam int PIPE_MEMWB  = 4;
    localparam int STALL_REQ_W = 4;

    typedef enum logic [1:0] {
        RUN,
        WAIT_IF,
        REDIRECT
    } pipe_ctrl_state_e;

    // Deepest requesting stage plus one; the deepest request decides the bubble position.
    function automatic logic [2:0] stall_depth(input logic [STALL_REQ_W-1:0] req);
        stall_depth = 3'd0;
        for (int i = 0; i < STALL_REQ_W; i++) begin
            if (req[i]) stall_depth = 3'(i + 1);
        end
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the five-register pipeline, with a
// deferred PC redirect when an exception meets an uncancellable fetch.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [STALL_REQ_W-1:0] stall_req_i,
    input  logic                   if_busy_i,
    input  logic                   exc_valid_i,
    input  logic [31:0]            exc_target_i,
    output logic [4:0]             stall_o,
    output logic [4:0]             flush_o,
    output logic                   redirect_o,
    output logic [31:0]            redirect_pc_o,
    output logic [CNT_W-1:0]       stall_cnt_o
);

    pipe_ctrl_state_e state_q, state_d;
    logic [31:0]      target_q, target_d;
    logic [4:0]       stall, flush;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic [2:0]       depth;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= RUN;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        stall       = '0;
        flush       = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        depth       = stall_depth(stall_req_i);
        unique case (state_q)
            RUN: begin
                if (exc_valid_i) begin
                    flush[PIPE_MEMWB:PIPE_IFID] = 4'b1111;
                    if (!if_busy_i) begin
                        redirect    = 1'b1;
                        redirect_pc = exc_target_i;
                    end else begin
                        stall[PIPE_PC] = 1'b1;
                        target_d       = exc_target_i;
                        state_d        = WAIT_IF;
                    end
                end else begin
                    // Hold every register in front of the deepest stall, bubble the one after it.
                    case (depth)
                        3'd1: begin
                            stall               = 5'b00001;
                            flush[PIPE_IFID]    = 1'b1;
                        end
                        3'd2: begin
                            stall               = 5'b00011;
                            flush[PIPE_IDEX]    = 1'b1;
                        end
                        3'd3: begin
                            stall               = 5'b00111;
                            flush[PIPE_EXMEM]   = 1'b1;
                        end
                        3'd4: begin
                            stall               = 5'b01111;
                            flush[PIPE_MEMWB]   = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            WAIT_IF: begin
                stall[PIPE_PC]              = 1'b1;
                flush[PIPE_MEMWB:PIPE_IFID] = 4'b1111;
                if (!if_busy_i) state_d = REDIRECT;
            end
            REDIRECT: begin
                redirect                    = 1'b1;
                redirect_pc                 = target_q;
                flush[PIPE_MEMWB:PIPE_IFID] = 4'b1111;
                state_d                     = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Outputs are forced quiet for the whole time reset is held.
    assign stall_o       = rst_ni ? stall       : '0;
    assign flush_o       = rst_ni ? flush       : '0;
    assign redirect_o    = rst_ni ? redirect    : 1'b0;
    assign redirect_pc_o = rst_ni ? redirect_pc : '0;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .inc   (stall_o[PIPE_PC]),
        .count (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl with a 4-bit stall counter so that
// saturation is reachable in a short run.
module tb_pipe_ctrl;

    localparam int CNT_W = 4;

    typedef struct {
        string      tag;
        logic [4:0] stall;
        logic [4:0] flush;
        logic       redirect;
        logic [31:0] pc;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [3:0]       stall_req;
    logic             if_busy;
    logic             exc_valid;
    logic [31:0]      exc_target;
    logic [4:0]       stall;
    logic [4:0]       flush;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] stall_cnt;

    exp_t             sb[$];
    int               total = 0;
    int               bad   = 0;
    logic [CNT_W-1:0] model_cnt = '0;

    pipe_ctrl #(
        .CNT_W(CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .stall_req_i  (stall_req),
        .if_busy_i    (if_busy),
        .exc_valid_i  (exc_valid),
        .exc_target_i (exc_target),
        .stall_o      (stall),
        .flush_o      (flush),
        .redirect_o   (redirect),
        .redirect_pc_o(redirect_pc),
        .stall_cnt_o  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of inputs at the falling edge and queues what the outputs must be.
    task automatic applyStimulus(input string tag, input logic rst, input logic [3:0] req,
                                 input logic busy, input logic exc, input logic [31:0] tgt,
                                 input logic [4:0] e_stall, input logic [4:0] e_flush,
                                 input logic e_redir, input logic [31:0] e_pc);
        exp_t e;
        @(negedge clk);
        rst_n      = rst;
        stall_req  = req;
        if_busy    = busy;
        exc_valid  = exc;
        exc_target = tgt;
        if (!rst) model_cnt = '0;
        e.tag      = tag;
        e.stall    = e_stall;
        e.flush    = e_flush;
        e.redirect = e_redir;
        e.pc       = e_pc;
        e.cnt      = model_cnt;
        sb.push_back(e);
        if (rst && e_stall[0] && (model_cnt != '1)) model_cnt = model_cnt + 4'd1;
    endtask

    task automatic checkOutput();
        exp_t e;
        #1;
        e = sb.pop_front();
        total++;
        assert (stall === e.stall) else begin
            bad++;
            $error("[TB] FAIL %s stall observed=%b expected=%b", e.tag, stall, e.stall);
        end
        total++;
        assert (flush === e.flush) else begin
            bad++;
            $error("[TB] FAIL %s flush observed=%b expected=%b", e.tag, flush, e.flush);
        end
        total++;
        assert (redirect === e.redirect) else begin
            bad++;
            $error("[TB] FAIL %s redirect observed=%b expected=%b", e.tag, redirect, e.redirect);
        end
        total++;
        assert (redirect_pc === e.pc) else begin
            bad++;
            $error("[TB] FAIL %s redirect_pc observed=%h expected=%h", e.tag, redirect_pc, e.pc);
        end
        total++;
        assert (stall_cnt === e.cnt) else begin
            bad++;
            $error("[TB] FAIL %s stall_cnt observed=%0d expected=%0d", e.tag, stall_cnt, e.cnt);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        stall_req  = 4'b1111;
        if_busy    = 1'b1;
        exc_valid  = 1'b1;
        exc_target = 32'hFFFF_FFFF;

        // Reset held with every request active
        applyStimulus("reset0", 1'b0, 4'b1111, 1'b1, 1'b1, 32'hFFFF_FFFF, 5'b00000, 5'b00000, 1'b0, 32'h0);
        checkOutput();
        applyStimulus("reset1", 1'b0, 4'b1111, 1'b0, 1'b1, 32'h1234_5678, 5'b00000, 5'b00000, 1'b0, 32'h0);
        checkOutput();

        applyStimulus("idle", 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 5'b00000, 5'b00000, 1'b0, 32'h0);
        checkOutput();

        // Load-use stall for three cycles
        for (int i = 0; i < 3; i++) begin
            applyStimulus("id_stall", 1'b1, 4'b0010, 1'b0, 1'b0, 32'h0, 5'b00011, 5'b00100, 1'b0, 32'h0);
            checkOutput();
        end
        applyStimulus("cnt_after_id", 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 5'b00000, 5'b00000, 1'b0, 32'h0);
        checkOutput();

        applyStimulus("deepest_wins", 1'b1, 4'b1001, 1'b0, 1'b0, 32'h0, 5'b01111, 5'b10000, 1'b0, 32'h0);
        checkOutput();
        applyStimulus("ex_stall", 1'b1, 4'b0100, 1'b0, 1'b0, 32'h0, 5'b00111, 5'b01000, 1'b0, 32'h0);
        checkOutput();
        applyStimulus("if_stall", 1'b1, 4'b0001, 1'b0, 1'b0, 32'h0, 5'b00001, 5'b00010, 1'b0, 32'h0);
        checkOutput();

        // Exception beats a MEM stall and redirects in the same cycle
        applyStimulus("exc_now", 1'b1, 4'b1000, 1'b0, 1'b1, 32'hBFC0_0380, 5'b00000, 5'b11110, 1'b1, 32'hBFC0_0380);
        checkOutput();
        applyStimulus("after_exc", 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 5'b00000, 5'b00000, 1'b0, 32'h0);
        checkOutput();

        // Exception during a busy fetch: four held cycles, a fresh exception ignored
        applyStimulus("exc_busy", 1'b1, 4'b0000, 1'b1, 1'b1, 32'h8000_0180, 5'b00001, 5'b11110, 1'b0, 32'h0);
        checkOutput();
        applyStimulus("wait1", 1'b1, 4'b0000, 1'b1, 1'b0, 32'h0, 5'b00001, 5'b11110, 1'b0, 32'h0);
        checkOutput();
        applyStimulus("wait_fresh_exc", 1'b1, 4'b1111, 1'b1, 1'b1, 32'h1234_5678, 5'b00001, 5'b11110, 1'b0, 32'h0);
        checkOutput();
        applyStimulus("wait3", 1'b1, 4'b0000, 1'b1, 1'b0, 32'h0, 5'b00001, 5'b11110, 1'b0, 32'h0);
        checkOutput();
        applyStimulus("busy_drop", 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 5'b00001, 5'b11110, 1'b0, 32'h0);
        checkOutput();
        applyStimulus("redirect", 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 5'b00000, 5'b11110, 1'b1, 32'h8000_0180);
        checkOutput();
        applyStimulus("after_redirect", 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 5'b00000, 5'b00000, 1'b0, 32'h0);
        checkOutput();

        // Drive the counter through E to F and confirm it sticks
        for (int i = 0; i < 5; i++) begin
            applyStimulus("sat_stall", 1'b1, 4'b0001, 1'b0, 1'b0, 32'h0, 5'b00001, 5'b00010, 1'b0, 32'h0);
            checkOutput();
        end
        applyStimulus("sat_hold", 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 5'b00000, 5'b00000, 1'b0, 32'h0);
        checkOutput();

        // Reset pulse while waiting on the fetch discards the pending redirect
        applyStimulus("wait_again", 1'b1, 4'b0000, 1'b1, 1'b1, 32'hDEAD_0000, 5'b00001, 5'b11110, 1'b0, 32'h0);
        checkOutput();
        applyStimulus("wait_again2", 1'b1, 4'b0000, 1'b1, 1'b0, 32'h0, 5'b00001, 5'b11110, 1'b0, 32'h0);
        checkOutput();
        applyStimulus("rst_in_wait", 1'b0, 4'b0000, 1'b1, 1'b0, 32'h0, 5'b00000, 5'b00000, 1'b0, 32'h0);
        checkOutput();
        applyStimulus("post_rst0", 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 5'b00000, 5'b00000, 1'b0, 32'h0);
        checkOutput();
        applyStimulus("post_rst1", 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 5'b00000, 5'b00000, 1'b0, 32'h0);
        checkOutput();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
